// File: rtl/pixels_upscaling.sv
// Streaming 2x nearest-neighbour upscaler: buffers one input row, then replays it
// twice with every pixel doubled horizontally, producing 2x2 blocks per input pixel.
module pixels_upscaling #(
  parameter int resolution = 8,
  parameter int IN_W       = 28,
  parameter int IN_H       = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [resolution-1:0] in_pixel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [resolution-1:0] out_pixel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_eol,
  output logic                  out_eof
);

  localparam int IC_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int OC_W = $clog2(2 * IN_W);
  localparam int RW_W = (IN_H > 1) ? $clog2(IN_H) : 1;

  localparam logic [IC_W-1:0] IN_LAST  = IC_W'(IN_W - 1);
  localparam logic [OC_W-1:0] OUT_LAST = OC_W'(2 * IN_W - 1);
  localparam logic [RW_W-1:0] ROW_LAST = RW_W'(IN_H - 1);

  typedef enum logic {LOAD, EMIT} state_t;

  state_t                r_state, w_state_nxt;
  logic [IC_W-1:0]       r_in_col, w_in_col_nxt;
  logic [OC_W-1:0]       r_out_col, w_out_col_nxt;
  logic                  r_rep, w_rep_nxt;
  logic [RW_W-1:0]       r_row, w_row_nxt;
  logic                  r_in_ready, w_in_ready_nxt;
  logic                  r_out_valid, w_out_valid_nxt;
  logic [resolution-1:0] r_out_pixel, w_out_pixel_nxt;
  logic                  r_out_eol, w_out_eol_nxt;
  logic                  r_out_eof, w_out_eof_nxt;
  logic                  w_buf_we;
  logic [OC_W-1:0]       w_col_inc;

  logic [resolution-1:0] r_buf [IN_W];

  assign w_col_inc = r_out_col + OC_W'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_in_col_nxt    = r_in_col;
    w_out_col_nxt   = r_out_col;
    w_rep_nxt       = r_rep;
    w_row_nxt       = r_row;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_out_pixel_nxt = r_out_pixel;
    w_out_eol_nxt   = r_out_eol;
    w_out_eof_nxt   = r_out_eof;
    w_buf_we        = 1'b0;

    case (r_state)
      LOAD: begin
        // in_ready rises one cycle after entering LOAD (after reset or after a replayed row)
        w_in_ready_nxt  = 1'b1;
        w_out_valid_nxt = 1'b0;
        w_out_eol_nxt   = 1'b0;
        w_out_eof_nxt   = 1'b0;
        if (in_valid && r_in_ready) begin
          w_buf_we = 1'b1;
          if (r_in_col == IN_LAST) begin
            w_in_col_nxt    = '0;
            w_in_ready_nxt  = 1'b0;
            w_state_nxt     = EMIT;
            w_out_valid_nxt = 1'b1;
            w_out_col_nxt   = '0;
            w_out_pixel_nxt = r_buf[0];
          end else begin
            w_in_col_nxt = r_in_col + IC_W'(1);
          end
        end
      end

      EMIT: begin
        if (r_out_valid && out_ready) begin
          if (r_out_col == OUT_LAST) begin
            w_out_col_nxt = '0;
            w_out_eol_nxt = 1'b0;
            w_out_eof_nxt = 1'b0;
            if (!r_rep) begin
              w_rep_nxt       = 1'b1;
              w_out_pixel_nxt = r_buf[0];
            end else begin
              w_rep_nxt       = 1'b0;
              w_out_valid_nxt = 1'b0;
              w_state_nxt     = LOAD;
              w_row_nxt       = (r_row == ROW_LAST) ? '0 : r_row + RW_W'(1);
            end
          end else begin
            w_out_col_nxt   = w_col_inc;
            w_out_pixel_nxt = r_buf[w_col_inc[OC_W-1:1]];
            w_out_eol_nxt   = (w_col_inc == OUT_LAST);
            w_out_eof_nxt   = (w_col_inc == OUT_LAST) && r_rep && (r_row == ROW_LAST);
          end
        end
      end

      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= LOAD;
      r_in_col    <= '0;
      r_out_col   <= '0;
      r_rep       <= 1'b0;
      r_row       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_pixel <= '0;
      r_out_eol   <= 1'b0;
      r_out_eof   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_col    <= w_in_col_nxt;
      r_out_col   <= w_out_col_nxt;
      r_rep       <= w_rep_nxt;
      r_row       <= w_row_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_pixel <= w_out_pixel_nxt;
      r_out_eol   <= w_out_eol_nxt;
      r_out_eof   <= w_out_eof_nxt;
    end
  end

  // Line buffer holds pure data and is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (w_buf_we) r_buf[r_in_col] <= in_pixel;
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_pixel = r_out_pixel;
  assign out_eol   = r_out_eol;
  assign out_eof   = r_out_eof;

endmodule
